// File: rtl/matmul_pkg.sv
// matmul_pkg: shared FSM encoding, size defaults and packed-bus element offsets
package matmul_pkg;
  localparam int DEF_MAX_DIM = 5;
  localparam int DEF_DATA_W = 8;
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CHECK = 3'd1;
  localparam logic [2:0] S_MAC = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;
  function automatic int elem_off(int slot, int r, int c, int md = DEF_MAX_DIM, int dw = DEF_DATA_W);
    return slot * md * md * dw + (r * md + c) * dw;
  endfunction
endpackage

// File: rtl/matmul_mac.sv
// matmul_mac: registered multiply-accumulate (clr/en) with saturate-or-truncate output; ports clk, reset, clr, en, sat, a, b -> res
module matmul_mac #(
  parameter int DATA_W = 8,
  parameter int ACC_W = 2 * DATA_W + 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              en,
  input  logic              sat,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] res
);
  logic [ACC_W-1:0] acc, ax, bx;
  assign ax = ACC_W'(a);
  assign bx = ACC_W'(b);
  always_ff @(posedge clk or posedge reset)
    if (reset) acc <= '0;
    else if (clr) acc <= '0;
    else if (en) acc <= acc + ax * bx;
  assign res = (sat && |acc[ACC_W-1:DATA_W]) ? '1 : acc[DATA_W-1:0];
endmodule

// File: rtl/seq_matrix_mul.sv
// seq_matrix_mul: sequential C=AxB, one MAC per clock, start/busy/done handshake, dim-error flag, sat/trunc output; ports clk, reset, start, sat_mode, a_m/a_n/b_m/b_n, matrices_in -> busy, done, valid, err, c_m, c_n, matrices_out
module seq_matrix_mul
  import matmul_pkg::*;
#(
  parameter int MAX_DIM = DEF_MAX_DIM,
  parameter int DATA_W = DEF_DATA_W,
  parameter int DIM_W = 3,
  parameter int ACC_W = 2 * DATA_W + 3
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  input  logic                              sat_mode,
  input  logic [DIM_W-1:0]                  a_m,
  input  logic [DIM_W-1:0]                  a_n,
  input  logic [DIM_W-1:0]                  b_m,
  input  logic [DIM_W-1:0]                  b_n,
  input  logic [2*MAX_DIM*MAX_DIM*DATA_W-1:0] matrices_in,
  output logic                              busy,
  output logic                              done,
  output logic                              valid,
  output logic                              err,
  output logic [DIM_W-1:0]                  c_m,
  output logic [DIM_W-1:0]                  c_n,
  output logic [2*MAX_DIM*MAX_DIM*DATA_W-1:0] matrices_out
);
  localparam int W = 2 * MAX_DIM * MAX_DIM * DATA_W;
  localparam logic [DIM_W-1:0] MDV = DIM_W'(MAX_DIM);
  localparam logic [DIM_W-1:0] ONE = DIM_W'(1);
  logic [2:0] state;
  logic [DIM_W-1:0] am, an, bm, bn, i, j, k;
  logic [W-1:0] mat;
  logic sat, dim_bad;
  logic [DATA_W-1:0] a_el, b_el, res;
  assign busy = state != S_IDLE;
  assign done = state == S_DONE;
  assign dim_bad = am == '0 || an == '0 || bm == '0 || bn == '0 ||
                   am > MDV || an > MDV || bm > MDV || bn > MDV || an != bm;
  assign a_el = mat[elem_off(0, int'(i), int'(k), MAX_DIM, DATA_W) +: DATA_W];
  assign b_el = mat[elem_off(1, int'(k), int'(j), MAX_DIM, DATA_W) +: DATA_W];
  matmul_mac #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_mac (
    .clk(clk),
    .reset(reset),
    .clr(state == S_CHECK || state == S_WRITE),
    .en(state == S_MAC),
    .sat(sat),
    .a(a_el),
    .b(b_el),
    .res(res)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= S_IDLE;
      {am, an, bm, bn, i, j, k, c_m, c_n} <= '0;
      mat <= '0;
      sat <= 1'b0;
      valid <= 1'b0;
      err <= 1'b0;
      matrices_out <= '0;
    end else case (state)
      S_IDLE: if (start) begin
        {am, an, bm, bn} <= {a_m, a_n, b_m, b_n};
        mat <= matrices_in;
        sat <= sat_mode;
        valid <= 1'b0;
        err <= 1'b0;
        matrices_out <= '0;
        state <= S_CHECK;
      end
      S_CHECK: begin
        {i, j, k} <= '0;
        err <= dim_bad;
        c_m <= dim_bad ? '0 : am;
        c_n <= dim_bad ? '0 : bn;
        state <= dim_bad ? S_DONE : S_MAC;
      end
      S_MAC: begin
        k <= (k == an - ONE) ? k : k + ONE;
        state <= (k == an - ONE) ? S_WRITE : S_MAC;
      end
      S_WRITE: begin
        matrices_out[elem_off(0, int'(i), int'(j), MAX_DIM, DATA_W) +: DATA_W] <= res;
        k <= '0;
        // indices return to 0 after the last element so operand reads stay in range
        j <= (j == c_n - ONE) ? '0 : j + ONE;
        i <= (j != c_n - ONE) ? i : (i == c_m - ONE) ? '0 : i + ONE;
        valid <= j == c_n - ONE && i == c_m - ONE;
        state <= (j == c_n - ONE && i == c_m - ONE) ? S_DONE : S_MAC;
      end
      default: state <= S_IDLE;
    endcase
endmodule
